sysid_check_master: RTL and testbench



---
 rtl/sysid_check_pkg.sv | 19 +
 rtl/sysid_check_master.sv | 195 +++++++++++++++++++
 tb/tb_sysid_check_master.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID check master.
// FSM state encoding, slave word addresses and stall counter width.
package sysid_check_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        LAT_ID,
        RD_TS,
        LAT_TS,
        FIN
    } state_e;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    localparam int STALL_W = 16;

endpackage

// File: rtl/sysid_check_master.sv
// Avalon-MM master that reads the system ID and timestamp words and compares them.
// Optional single retry on compare failure: define SYSID_CHECK_RETRY_EN.
module sysid_check_master
    import sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1575277317,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        address,
    output logic        read,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [1:0]         LAT_N = 2'(READ_LATENCY);
    localparam logic [STALL_W-1:0] TO_N  = STALL_W'(TIMEOUT_CYCLES);

    state_e             state_q, state_d;
    logic               addr_q, addr_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [1:0]         lat_q, lat_d;
    logic               id_ok_q, id_ok_d;
    logic               ts_ok_q, ts_ok_d;
    logic               tmo_q, tmo_d;
    logic [31:0]        id_val_q, id_val_d;
    logic [31:0]        ts_val_q, ts_val_d;
    logic               cap_id, cap_ts, fin_cmp;
`ifdef SYSID_CHECK_RETRY_EN
    logic               retry_q, retry_d;
`endif

    // Next-state, capture and handshake decode for the read sequence
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stall_d  = stall_q;
        lat_d    = lat_q;
        id_ok_d  = id_ok_q;
        ts_ok_d  = ts_ok_q;
        tmo_d    = tmo_q;
        id_val_d = id_val_q;
        ts_val_d = ts_val_q;
`ifdef SYSID_CHECK_RETRY_EN
        retry_d  = retry_q;
`endif
        cap_id   = 1'b0;
        cap_ts   = 1'b0;
        fin_cmp  = 1'b0;
        read     = 1'b0;
        done     = 1'b0;
        busy     = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RD_ID;
                    addr_d   = ADDR_ID;
                    stall_d  = '0;
                    lat_d    = '0;
                    id_ok_d  = 1'b0;
                    ts_ok_d  = 1'b0;
                    tmo_d    = 1'b0;
                    id_val_d = '0;
                    ts_val_d = '0;
`ifdef SYSID_CHECK_RETRY_EN
                    retry_d  = 1'b0;
`endif
                end
            end
            RD_ID, RD_TS: begin
                read = 1'b1;
                if (!waitrequest) begin
                    stall_d = '0;
                    if (LAT_N == 2'd0) begin
                        if (state_q == RD_ID) begin
                            cap_id  = 1'b1;
                            state_d = RD_TS;
                            addr_d  = ADDR_TS;
                        end else begin
                            cap_ts  = 1'b1;
                            fin_cmp = 1'b1;
                            state_d = FIN;
                        end
                    end else begin
                        lat_d   = 2'd1;
                        state_d = (state_q == RD_ID) ? LAT_ID : LAT_TS;
                    end
                end else begin
                    stall_d = stall_q + 1'b1;
                    if (stall_d == TO_N) begin
                        state_d = FIN;
                        tmo_d   = 1'b1;
                        id_ok_d = 1'b0;
                        ts_ok_d = 1'b0;
                    end
                end
            end
            LAT_ID: begin
                if (lat_q == LAT_N) begin
                    cap_id  = 1'b1;
                    state_d = RD_TS;
                    addr_d  = ADDR_TS;
                    stall_d = '0;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            LAT_TS: begin
                if (lat_q == LAT_N) begin
                    cap_ts  = 1'b1;
                    fin_cmp = 1'b1;
                    state_d = FIN;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
`ifdef SYSID_CHECK_RETRY_EN
                if (!tmo_q && !(id_ok_q && ts_ok_q) && !retry_q) begin
                    done     = 1'b0;
                    retry_d  = 1'b1;
                    state_d  = RD_ID;
                    addr_d   = ADDR_ID;
                    stall_d  = '0;
                    id_ok_d  = 1'b0;
                    ts_ok_d  = 1'b0;
                    id_val_d = '0;
                    ts_val_d = '0;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        if (cap_id) id_val_d = readdata;
        if (cap_ts) ts_val_d = readdata;
        if (fin_cmp) begin
            id_ok_d = (id_val_d == EXPECTED_ID);
            ts_ok_d = (ts_val_d == EXPECTED_TS);
        end
    end

    // State, counters and result registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= ADDR_ID;
            stall_q  <= '0;
            lat_q    <= '0;
            id_ok_q  <= 1'b0;
            ts_ok_q  <= 1'b0;
            tmo_q    <= 1'b0;
            id_val_q <= '0;
            ts_val_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            stall_q  <= stall_d;
            lat_q    <= lat_d;
            id_ok_q  <= id_ok_d;
            ts_ok_q  <= ts_ok_d;
            tmo_q    <= tmo_d;
            id_val_q <= id_val_d;
            ts_val_q <= ts_val_d;
        end
    end

`ifdef SYSID_CHECK_RETRY_EN
    // Remembers that the one permitted rerun has been used
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) retry_q <= 1'b0;
        else          retry_q <= retry_d;
    end
`endif

    assign address  = addr_q;
    assign id_ok    = id_ok_q;
    assign ts_ok    = ts_ok_q;
    assign timeout  = tmo_q;
    assign id_value = id_val_q;
    assign ts_value = ts_val_q;

endmodule

// File: tb/tb_sysid_check_master.sv
// Randomized bench: two masters (latency 0 / latency 2 with short timeout)
// against behavioural stalling slaves and an arithmetic timing/result model.
module tb_sysid_check_master;

    localparam logic [31:0] ETS  = 32'd1575277317;
    localparam logic [31:0] EID1 = 32'hCAFE0001;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [1:0] start = '0;
    logic [1:0] ad, rd, wr, bz, dn, iok, tok, tmo;
    logic [1:0][31:0] rdat, idv, tsv;
    logic [1:0][31:0] id_word = '0;
    logic [1:0][31:0] ts_word = '0;
    int tgt_id[2];
    int tgt_ts[2];
    int scnt[2];
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sysid_check_master u0 (
        .clock(clock), .reset_n(reset_n), .start(start[0]),
        .address(ad[0]), .read(rd[0]), .waitrequest(wr[0]),
        .readdata(rdat[0]), .busy(bz[0]), .done(dn[0]),
        .id_ok(iok[0]), .ts_ok(tok[0]), .timeout(tmo[0]),
        .id_value(idv[0]), .ts_value(tsv[0])
    );

    sysid_check_master #(
        .EXPECTED_ID(EID1), .READ_LATENCY(2), .TIMEOUT_CYCLES(4)
    ) u1 (
        .clock(clock), .reset_n(reset_n), .start(start[1]),
        .address(ad[1]), .read(rd[1]), .waitrequest(wr[1]),
        .readdata(rdat[1]), .busy(bz[1]), .done(dn[1]),
        .id_ok(iok[1]), .ts_ok(tok[1]), .timeout(tmo[1]),
        .id_value(idv[1]), .ts_value(tsv[1])
    );

    // Slave: stalls a chosen number of cycles per read, data selected by address
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            wr[i]   = rd[i] && (scnt[i] < (ad[i] ? tgt_ts[i] : tgt_id[i]));
            rdat[i] = ad[i] ? ts_word[i] : id_word[i];
        end
    end

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++)
            scnt[i] <= (rd[i] && wr[i]) ? scnt[i] + 1 : 0;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_seq(input int d, input int sid, input int sts,
                           input logic [31:0] idw, input logic [31:0] tsw);
        int L, TO, n, dcyc, tss;
        logic [31:0] eid, eidv, etsv;
        logic eiok, etok, etmo;
        L   = d ? 2 : 0;
        TO  = d ? 4 : 255;
        eid = d ? EID1 : 32'h0;
        eidv = '0; etsv = '0; eiok = 1'b0; etok = 1'b0; etmo = 1'b0;
        if (sid >= TO) begin
            dcyc = 1 + TO;
            etmo = 1'b1;
        end else begin
            eidv = idw;
            tss  = 1 + sid + 1 + L;
            if (sts >= TO) begin
                dcyc = tss + TO;
                etmo = 1'b1;
            end else begin
                etsv = tsw;
                dcyc = tss + sts + 1 + L;
                eiok = (idw == eid);
                etok = (tsw == ETS);
            end
        end
        tgt_id[d] = sid;
        tgt_ts[d] = sts;
        id_word[d] = idw;
        ts_word[d] = tsw;
        @(negedge clock);
        start[d] = 1'b1;
        @(negedge clock);
        start[d] = 1'b0;
        n = 1;
        chk("busy_after_start", {31'd0, bz[d]}, 32'd1);
        while (dn[d] !== 1'b1 && n < 400) begin
            start[d] = (n == 2);
            @(negedge clock);
            n++;
        end
        start[d] = 1'b1;
        chk("done_cycle", n, dcyc);
        chk("id_ok", {31'd0, iok[d]}, {31'd0, eiok});
        chk("ts_ok", {31'd0, tok[d]}, {31'd0, etok});
        chk("timeout", {31'd0, tmo[d]}, {31'd0, etmo});
        chk("id_value", idv[d], eidv);
        chk("ts_value", tsv[d], etsv);
        @(negedge clock);
        start[d] = 1'b0;
        chk("done_one_cycle", {31'd0, dn[d]}, 32'd0);
        chk("idle_after_done", {31'd0, bz[d]}, 32'd0);
        @(negedge clock);
        chk("start_at_done_ignored", {31'd0, bz[d]}, 32'd0);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ctrl", {25'd0, rd[d], ad[d], bz[d], dn[d], iok[d], tok[d], tmo[d]}, 32'd0);
            chk("rst_idv", idv[d], 32'd0);
            chk("rst_tsv", tsv[d], 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clock);

        run_seq(0, 0, 0, 32'h0, ETS);
        run_seq(0, 0, 0, 32'h0, 32'h12345678);
        run_seq(0, 2, 1, 32'h1, ETS);
        run_seq(0, 1000, 0, 32'h0, ETS);
        run_seq(1, 3, 0, EID1, ETS);
        run_seq(1, 1000, 0, EID1, ETS);
        run_seq(1, 3, 4, EID1, ETS);
        run_seq(1, 0, 3, EID1, 32'hFFFFFFFF);

        for (int i = 0; i < 24; i++) begin
            int d, sid, sts;
            logic [31:0] w_id, w_ts;
            d = i % 2;
            if (d == 0) begin
                sid = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 4));
                sts = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 4));
            end else begin
                sid = int'($urandom_range(0, 5));
                sts = int'($urandom_range(0, 5));
            end
            w_id = $urandom_range(0, 1) ? (d ? EID1 : 32'h0) : $urandom;
            w_ts = $urandom_range(0, 1) ? ETS : $urandom;
            run_seq(d, sid, sts, w_id, w_ts);
        end

        tgt_id[1] = 0;
        tgt_ts[1] = 0;
        id_word[1] = 32'hDEADBEEF;
        ts_word[1] = ETS;
        @(negedge clock);
        start[1] = 1'b1;
        @(negedge clock);
        start[1] = 1'b0;
        k = 0;
        while (!(rd[1] == 1'b0 && ad[1] == 1'b1 && bz[1] == 1'b1 && dn[1] == 1'b0) && k < 50) begin
            @(negedge clock);
            k++;
        end
        chk("reach_lat_ts", {31'd0, k < 50}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_ctrl", {25'd0, rd[1], ad[1], bz[1], dn[1], iok[1], tok[1], tmo[1]}, 32'd0);
        chk("midrst_idv", idv[1], 32'd0);
        chk("midrst_tsv", tsv[1], 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("no_done_after_rst", {30'd0, bz[1], dn[1]}, 32'd0);
        end
        run_seq(1, 1, 2, EID1, ETS);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
